descarrega_matriz: RTL and testbench

Writeback engine for the matrix coprocessor: the store-side counterpart of the matrix loader. On `start` it captures the packed 5x5 result matrix (25 elements of 9 bits, 225 bits total) and the active size N. It then writes the N×N active elements one per accepted cycle into the data memory through a simple write-request/ready handshake. It sits between the arithmetic core's `matriz_resultante` bus and the memory write port.

---
 rtl/descarrega_matriz.sv | 147 ++++++++++++++
 tb/tb_descarrega_matriz.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/descarrega_matriz.sv
`default_nettype none
// ============================================================================
// Module      : descarrega_matriz
// Description : Matrix writeback engine. On start it captures the packed 5x5
//               result matrix, size N and base address, then writes the N x N
//               active elements (stride-5 address layout) one per accepted
//               cycle through a we/ready memory handshake.
//               Optional macro DESCARREGA_ZERA_EN: always write all 25
//               positions, with inactive positions written as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module descarrega_matriz #(
  parameter int ELEM_W = 9,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4:0]            tamanho,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [25*ELEM_W-1:0]  matriz_resultante,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [ELEM_W-1:0]     mem_wdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  erro
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_WRITE = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  logic [1:0]           r_state;
  logic [25*ELEM_W-1:0] r_mat;
  logic [2:0]           r_n;
  logic [ADDR_W-1:0]    r_base;
  logic [2:0]           r_i;
  logic [2:0]           r_j;

  logic                 w_valid_n;
  logic [2:0]           w_lim;
  logic                 w_last_col;
  logic                 w_last;
  logic [2:0]           w_ni;
  logic [2:0]           w_nj;
  logic [4:0]           w_idx;
  logic [ELEM_W-1:0]    w_elem;
  logic [ELEM_W-1:0]    w_wdata;
  logic [ADDR_W-1:0]    w_addr;

  // Next position, address and data for the element after the current one
  always_comb begin
    w_valid_n = (tamanho != 5'd0) && (tamanho <= 5'd5);
`ifdef DESCARREGA_ZERA_EN
    w_lim = 3'd5;
`else
    w_lim = r_n;
`endif
    w_last_col = (r_j == (w_lim - 3'd1));
    w_last     = w_last_col && (r_i == (w_lim - 3'd1));
    w_ni       = w_last_col ? (r_i + 3'd1) : r_i;
    w_nj       = w_last_col ? 3'd0 : (r_j + 3'd1);
    // Linear index of (i,j) in the stride-5 layout; only used when not last,
    // so it always lies in 0..24
    w_idx      = (5'(w_ni) * 5'd5) + 5'(w_nj);
    w_elem     = '0;
    for (int k = 0; k < 25; k++) begin
      if (w_idx == 5'(k)) begin
        w_elem = r_mat[k*ELEM_W +: ELEM_W];
      end
    end
`ifdef DESCARREGA_ZERA_EN
    w_wdata = ((w_ni < r_n) && (w_nj < r_n)) ? w_elem : '0;
`else
    w_wdata = w_elem;
`endif
    // Address wraps silently modulo 2^ADDR_W
    w_addr = r_base + ADDR_W'(w_idx);
  end

  // Control FSM with registered memory-port and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_mat     <= '0;
      r_n       <= 3'd0;
      r_base    <= '0;
      r_i       <= 3'd0;
      r_j       <= 3'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      erro      <= 1'b0;
    end else begin
      done <= 1'b0;
      erro <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            if (w_valid_n) begin
              r_mat     <= matriz_resultante;
              r_n       <= tamanho[2:0];
              r_base    <= base_addr;
              r_i       <= 3'd0;
              r_j       <= 3'd0;
              // Element (0,0) is always active, so it comes straight off the bus
              mem_we    <= 1'b1;
              mem_addr  <= base_addr;
              mem_wdata <= matriz_resultante[ELEM_W-1:0];
              busy      <= 1'b1;
              r_state   <= c_WRITE;
            end else begin
              erro <= 1'b1;
            end
          end
        end
        c_WRITE: begin
          if (mem_ready) begin
            if (w_last) begin
              mem_we  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= c_DONE;
            end else begin
              r_i       <= w_ni;
              r_j       <= w_nj;
              mem_addr  <= w_addr;
              mem_wdata <= w_wdata;
            end
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_descarrega_matriz.sv
`default_nettype none
// ============================================================================
// Module      : tb_descarrega_matriz
// Description : Self-checking bench for descarrega_matriz. Table-driven cases,
//               hand-written reset sequence and randomized transfers, all
//               checked against a write-list model built from the matrix,
//               size and base address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_descarrega_matriz;

  logic         clk;
  logic         rst;
  logic         start;
  logic [4:0]   tamanho;
  logic [7:0]   base_addr;
  logic [224:0] matriz_resultante;
  logic         mem_we;
  logic [7:0]   mem_addr;
  logic [8:0]   mem_wdata;
  logic         mem_ready;
  logic         busy;
  logic         done;
  logic         erro;

  int n_cmp = 0;
  int n_bad = 0;

  descarrega_matriz #(.ELEM_W(9), .ADDR_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .tamanho           (tamanho),
    .base_addr         (base_addr),
    .matriz_resultante (matriz_resultante),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_ready         (mem_ready),
    .busy              (busy),
    .done              (done),
    .erro              (erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         tam;
    logic [7:0] base;
    int         mode;       // 0: 5i+j+1, 1: random, 2: all 0x1FF
    int         pct;        // percent of cycles with mem_ready low
    int         stall_at;   // write index to hold off
    int         stall_len;  // cycles held off at stall_at
    bit         chg;        // disturb inputs / re-start during transfer
    int         exp_writes;
    bit         exp_erro;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_count(input int tam);
    if (tam < 1 || tam > 5) return 0;
`ifdef DESCARREGA_ZERA_EN
    return 25;
`else
    return tam * tam;
`endif
  endfunction

  function automatic logic [224:0] make_mat(input int mode);
    logic [224:0] m;
    m = '0;
    for (int k = 0; k < 25; k++) begin
      case (mode)
        0:       m[k*9 +: 9] = 9'(k + 1);
        1:       m[k*9 +: 9] = 9'($urandom);
        default: m[k*9 +: 9] = 9'h1FF;
      endcase
    end
    return m;
  endfunction

  task automatic run_case(input int tam, input logic [7:0] base, input logic [224:0] mat,
                          input int pct, input int stall_at, input int stall_len,
                          input bit chg, input int exp_writes, input bit exp_erro);
    logic [7:0] ea[$];
    logic [8:0] ed[$];
    int lim, idx, cyc, stalls, stalled;
    bit rdy;
    tamanho           = 5'(tam);
    base_addr         = base;
    matriz_resultante = mat;
    mem_ready         = 1'b0;
    start             = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (exp_erro) begin
      check("erro_pulse", 32'(erro), 32'd1);
      check("erro_busy", 32'(busy), 32'd0);
      check("erro_we", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
      check("erro_clear", 32'(erro), 32'd0);
      check("erro_we2", 32'(mem_we), 32'd0);
      check("erro_busy2", 32'(busy), 32'd0);
      return;
    end
    // Expected write list: rows of the written square, stride 5 in memory
`ifdef DESCARREGA_ZERA_EN
    lim = 5;
`else
    lim = tam;
`endif
    for (int i = 0; i < lim; i++) begin
      for (int j = 0; j < lim; j++) begin
        ea.push_back(8'(int'(base) + 5*i + j));
        ed.push_back((i < tam && j < tam) ? mat[(5*i + j)*9 +: 9] : 9'd0);
      end
    end
    idx = 0; stalls = 0; stalled = 0;
    for (cyc = 1; cyc <= 400; cyc++) begin
      if (done) break;
      check("busy", 32'(busy), 32'd1);
      check("we_high", 32'(mem_we), 32'd1);
      check("no_erro", 32'(erro), 32'd0);
      if (idx < ea.size()) begin
        check("addr", 32'(mem_addr), 32'(ea[idx]));
        check("wdata", 32'(mem_wdata), 32'(ed[idx]));
      end else begin
        check("overrun_idx", 32'(idx), 32'(ea.size() - 1));
      end
      rdy = ($urandom_range(99) >= 32'(pct));
      if (idx == stall_at && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end
      mem_ready = rdy;
      if (rdy && mem_we) idx++;
      else stalls++;
      if (chg) begin
        matriz_resultante = make_mat(1);
        tamanho           = 5'($urandom);
        base_addr         = 8'($urandom);
        start             = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    check("done", 32'(done), 32'd1);
    check("latency", 32'(cyc), 32'(ea.size() + stalls + 1));
    check("writes", 32'(idx), 32'(exp_writes));
    check("busy_at_done", 32'(busy), 32'd0);
    check("we_at_done", 32'(mem_we), 32'd0);
    // A start in the DONE cycle must be ignored
    if (chg) begin
      start   = 1'b1;
      tamanho = 5'd2;
    end else begin
      start = 1'b0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_pulse_end", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_we", 32'(mem_we), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_erro"}, 32'(erro), 32'd0);
  endtask

  initial begin
    int acc, tam;
    bit timeout;
    vecs[0] = '{3,  8'h10, 0, 0,  -1, 0, 1'b0, exp_count(3), 1'b0};
    vecs[1] = '{2,  8'h00, 1, 0,   1, 3, 1'b0, exp_count(2), 1'b0};
    vecs[2] = '{0,  8'h00, 1, 0,  -1, 0, 1'b0, 0,            1'b1};
    vecs[3] = '{7,  8'h00, 1, 0,  -1, 0, 1'b0, 0,            1'b1};
    vecs[4] = '{4,  8'h40, 1, 0,  -1, 0, 1'b1, exp_count(4), 1'b0};
    vecs[5] = '{2,  8'h00, 2, 0,  -1, 0, 1'b0, exp_count(2), 1'b0};
    vecs[6] = '{5,  8'hF0, 1, 30, -1, 0, 1'b0, exp_count(5), 1'b0};
    vecs[7] = '{1,  8'hFF, 1, 0,  -1, 0, 1'b0, exp_count(1), 1'b0};
    vecs[8] = '{31, 8'h00, 1, 0,  -1, 0, 1'b0, 0,            1'b1};

    rst = 1'b1; start = 1'b0; tamanho = '0; base_addr = '0;
    matriz_resultante = '0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 9; v++) begin
      run_case(vecs[v].tam, vecs[v].base, make_mat(vecs[v].mode), vecs[v].pct,
               vecs[v].stall_at, vecs[v].stall_len, vecs[v].chg,
               vecs[v].exp_writes, vecs[v].exp_erro);
    end

    // Reset in the middle of an N=5 transfer, after the 7th accept
    tamanho = 5'd5; base_addr = 8'h20; matriz_resultante = make_mat(1);
    start = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    acc = 0; timeout = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (mem_we) acc++;
      if (acc == 7) begin timeout = 1'b0; break; end
      @(posedge clk); #1;
    end
    check("rst_reach7_timeout", 32'(timeout), 32'd0);
    @(posedge clk); #1;
    check("rst_mid_busy", 32'(busy), 32'd1);
    rst = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("rst_after");
    run_case(5, 8'h20, make_mat(1), 0, -1, 0, 1'b0, exp_count(5), 1'b0);

    // Randomized transfers
    for (int r = 0; r < 20; r++) begin
      tam = int'($urandom_range(7));
      run_case(tam, 8'($urandom), make_mat(1), int'($urandom_range(50)), -1, 0,
               1'($urandom), exp_count(tam), (tam < 1 || tam > 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
